// File: rtl/dsram_responder.sv
// Word-organised synchronous RAM responder for the CPU data SRAM port, with
// read latency LAT, window check and optional statistics (macro DSRAM_STAT_EN).
module dsram_responder #(
  parameter int          AW   = 10,
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int          LAT  = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        range_err,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  if (LAT < 1 || LAT > 4) begin : g_lat_check
    $error("dsram_responder: LAT must be in 1..4");
  end

  localparam logic [31:0] WIN_MASK = (32'd1 << (AW + 2)) - 32'd1;

  // Handshake: every edge with data_sram_en=1 accepts one request (no
  // backpressure); its read word appears with a one-cycle data_sram_rvalid
  // pulse exactly LAT cycles later, in request order.

  logic          in_win;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic          accept;
  logic          wr_commit;

  logic [31:0]   mem_q [0:(1<<AW)-1];
  logic          v_q   [LAT];
  logic [31:0]   d_q   [LAT];
  logic          range_err_q;

  assign in_win    = ((data_sram_addr & ~WIN_MASK) == BASE);
  assign idx       = data_sram_addr[AW+1:2];
  assign accept    = resetn && data_sram_en;
  assign wr_commit = accept && (data_sram_wen != 4'h0) && in_win;
  assign rd_word   = in_win ? mem_q[idx] : 32'h0;

  // Memory is never reset; the non-blocking write makes same-edge reads
  // return the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wen[b]) mem_q[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  // Last stage doubles as the rdata register, so it only loads on a valid entry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) begin
        v_q[i] <= 1'b0;
        d_q[i] <= 32'h0;
      end
    end else begin
      v_q[0] <= data_sram_en;
      if (LAT > 1 || data_sram_en) d_q[0] <= rd_word;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
        if (i < LAT - 1 || v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)                range_err_q <= 1'b0;
    else if (accept && !in_win) range_err_q <= 1'b1;
  end

  assign data_sram_rdata  = d_q[LAT-1];
  assign data_sram_rvalid = v_q[LAT-1];
  assign range_err        = range_err_q;

`ifdef DSRAM_STAT_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      if (v_q[LAT-1]) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wr_commit)  wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = 32'h0;
  assign wr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder: three instances (LAT=1, LAT=3 with a
// non-zero BASE, LAT=4) driven one after another from a single sequence.
module tb_dsram_responder;

  localparam int N = 3;

`ifdef DSRAM_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn [N];
  logic        en     [N];
  logic [3:0]  wen    [N];
  logic [31:0] addr   [N];
  logic [31:0] wdata  [N];
  logic [31:0] rdata  [N];
  logic        rvalid [N];
  logic        rerr   [N];
  logic [31:0] rd_cnt [N];
  logic [31:0] wr_cnt [N];

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  dsram_responder #(.AW(10), .BASE(32'h0000_0000), .LAT(1)) u_lat1 (
    .clk(clk), .resetn(resetn[0]), .data_sram_en(en[0]), .data_sram_wen(wen[0]),
    .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]), .data_sram_rdata(rdata[0]),
    .data_sram_rvalid(rvalid[0]), .range_err(rerr[0]), .rd_cnt(rd_cnt[0]), .wr_cnt(wr_cnt[0]));

  dsram_responder #(.AW(10), .BASE(32'h1000_0000), .LAT(3)) u_lat3 (
    .clk(clk), .resetn(resetn[1]), .data_sram_en(en[1]), .data_sram_wen(wen[1]),
    .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]), .data_sram_rdata(rdata[1]),
    .data_sram_rvalid(rvalid[1]), .range_err(rerr[1]), .rd_cnt(rd_cnt[1]), .wr_cnt(wr_cnt[1]));

  dsram_responder #(.AW(10), .BASE(32'h0000_0000), .LAT(4)) u_lat4 (
    .clk(clk), .resetn(resetn[2]), .data_sram_en(en[2]), .data_sram_wen(wen[2]),
    .data_sram_addr(addr[2]), .data_sram_wdata(wdata[2]), .data_sram_rdata(rdata[2]),
    .data_sram_rvalid(rvalid[2]), .range_err(rerr[2]), .rd_cnt(rd_cnt[2]), .wr_cnt(wr_cnt[2]));

  function automatic logic [31:0] cnt(input logic [31:0] v);
    return STAT ? v : 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input logic e, input logic [3:0] w,
                     input logic [31:0] a, input logic [31:0] d);
    en[k]    = e;
    wen[k]   = w;
    addr[k]  = a;
    wdata[k] = d;
  endtask

  task automatic idle(input int k);
    req(k, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      resetn[k] = 1'b0;
      idle(k);
    end
    tick();
    tick();
    for (int k = 0; k < N; k++) resetn[k] = 1'b1;
    for (int k = 0; k < N; k++) begin
      chk("rst_rdata", rdata[k], 32'h0);
      chk("rst_rvalid", rvalid[k], 32'h0);
      chk("rst_range_err", rerr[k], 32'h0);
      chk("rst_rd_cnt", rd_cnt[k], 32'h0);
      chk("rst_wr_cnt", wr_cnt[k], 32'h0);
    end

    // ---- LAT=1: write then read ----
    req(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF); tick();
    chk("l1_wr_rvalid", rvalid[0], 32'h1);
    req(0, 1'b1, 4'h0, 32'h10, 32'h0); tick();
    chk("l1_rd_data", rdata[0], 32'hDEAD_BEEF);
    chk("l1_rd_rvalid", rvalid[0], 32'h1);
    idle(0); tick();
    chk("l1_idle_rvalid", rvalid[0], 32'h0);
    chk("l1_hold", rdata[0], 32'hDEAD_BEEF);
    chk("l1_wr_cnt", wr_cnt[0], cnt(32'd1));
    chk("l1_rd_cnt", rd_cnt[0], cnt(32'd2));

    // ---- byte lanes ----
    req(0, 1'b1, 4'hF, 32'h10, 32'h1122_3344); tick();
    req(0, 1'b1, 4'b0101, 32'h10, 32'hAABB_CCDD); tick();
    chk("lane_read_first", rdata[0], 32'h1122_3344);
    req(0, 1'b1, 4'h0, 32'h10, 32'h0); tick();
    chk("lane_merge", rdata[0], 32'h11BB_33DD);

    // ---- read-first collision ----
    req(0, 1'b1, 4'hF, 32'h10, 32'h1); tick();
    req(0, 1'b1, 4'hF, 32'h10, 32'h2); tick();
    chk("collide_old", rdata[0], 32'h1);
    req(0, 1'b1, 4'h0, 32'h10, 32'h0); tick();
    chk("collide_new", rdata[0], 32'h2);

    // ---- out of window on LAT=1 (0x1010 aliases idx 4) ----
    req(0, 1'b1, 4'hF, 32'h1010, 32'h55); tick();
    chk("oow_rdata", rdata[0], 32'h0);
    chk("oow_rvalid", rvalid[0], 32'h1);
    chk("oow_err", rerr[0], 32'h1);
    req(0, 1'b1, 4'h0, 32'h10, 32'h0); tick();
    chk("oow_mem_kept", rdata[0], 32'h2);
    idle(0); tick(); tick();
    chk("oow_err_sticky", rerr[0], 32'h1);
    chk("l1_rd_cnt_total", rd_cnt[0], cnt(32'd10));
    chk("l1_wr_cnt_total", wr_cnt[0], cnt(32'd5));
    resetn[0] = 1'b0; tick(); resetn[0] = 1'b1;
    chk("l1_rst_err", rerr[0], 32'h0);
    chk("l1_rst_rdata", rdata[0], 32'h0);
    chk("l1_rst_rd_cnt", rd_cnt[0], 32'h0);

    // ---- LAT=3, BASE=0x1000_0000: back-to-back reads ----
    req(1, 1'b1, 4'hF, 32'h1000_0000, 32'hA); tick();
    req(1, 1'b1, 4'hF, 32'h1000_0004, 32'hB); tick();
    req(1, 1'b1, 4'hF, 32'h1000_0008, 32'hC); tick();
    req(1, 1'b1, 4'hF, 32'h1000_0010, 32'h99); tick();
    idle(1); tick(); tick(); tick();
    chk("l3_drained", rvalid[1], 32'h0);
    exp_q.push_back(32'hA);
    exp_q.push_back(32'hB);
    exp_q.push_back(32'hC);
    req(1, 1'b1, 4'h0, 32'h1000_0000, 32'h0); tick();
    chk("l3_gap0", rvalid[1], 32'h0);
    req(1, 1'b1, 4'h0, 32'h1000_0004, 32'h0); tick();
    chk("l3_gap1", rvalid[1], 32'h0);
    req(1, 1'b1, 4'h0, 32'h1000_0008, 32'h0); tick();
    chk("l3_v0", rvalid[1], 32'h1);
    chk("l3_d0", rdata[1], exp_q.pop_front());
    idle(1); tick();
    chk("l3_v1", rvalid[1], 32'h1);
    chk("l3_d1", rdata[1], exp_q.pop_front());
    tick();
    chk("l3_v2", rvalid[1], 32'h1);
    chk("l3_d2", rdata[1], exp_q.pop_front());
    tick();
    chk("l3_end_rvalid", rvalid[1], 32'h0);
    chk("l3_hold", rdata[1], 32'hC);

    // ---- LAT=3 out of window ----
    req(1, 1'b1, 4'hF, 32'h0000_0010, 32'h77); tick();
    chk("l3_oow_err", rerr[1], 32'h1);
    req(1, 1'b1, 4'h0, 32'h1000_0010, 32'h0); tick();
    idle(1); tick();
    chk("l3_oow_rvalid", rvalid[1], 32'h1);
    chk("l3_oow_rdata", rdata[1], 32'h0);
    tick();
    chk("l3_oow_mem_kept", rdata[1], 32'h99);
    tick();
    chk("l3_err_sticky", rerr[1], 32'h1);
    resetn[1] = 1'b0; tick(); resetn[1] = 1'b1;
    chk("l3_rst_err", rerr[1], 32'h0);

    // ---- LAT=4: reset discards in-flight reads ----
    req(2, 1'b1, 4'hF, 32'h10, 32'h1234_5678); tick();
    idle(2); tick(); tick(); tick(); tick();
    req(2, 1'b1, 4'h0, 32'h10, 32'h0); tick();
    req(2, 1'b1, 4'h0, 32'h10, 32'h0); tick();
    resetn[2] = 1'b0;
    req(2, 1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF); tick();
    resetn[2] = 1'b1;
    idle(2);
    chk("l4_rst_rvalid", rvalid[2], 32'h0);
    chk("l4_rst_rdata", rdata[2], 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("l4_flushed_rvalid", rvalid[2], 32'h0);
    end
    chk("l4_rdata_still0", rdata[2], 32'h0);
    chk("l4_rd_cnt0", rd_cnt[2], 32'h0);
    chk("l4_wr_cnt0", wr_cnt[2], 32'h0);
    req(2, 1'b1, 4'h0, 32'h10, 32'h0); tick();
    idle(2); tick(); tick();
    chk("l4_lat_early", rvalid[2], 32'h0);
    tick();
    chk("l4_mem_intact_v", rvalid[2], 32'h1);
    chk("l4_mem_intact_d", rdata[2], 32'h1234_5678);
    tick();
    chk("l4_after_rvalid", rvalid[2], 32'h0);
    chk("l4_rd_cnt1", rd_cnt[2], cnt(32'd1));
    chk("l4_wr_cnt_still0", wr_cnt[2], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
